// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the pipeline (decode/writeback) and the register file.
// Both read ports, the byte-enabled write port and the reserve port travel
// together. There is no valid/ready pairing on this bus: RegWrite and Reserve
// are single-cycle strobes sampled on every rising clock edge, and the read
// addresses are level signals. No transfer is ever stalled by the register
// file, and ReadBusy is advisory status for the core's hazard logic.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();

    logic [ADDR_WIDTH-1:0]   ReadRegister1;
    logic [ADDR_WIDTH-1:0]   ReadRegister2;
    logic [DATA_WIDTH-1:0]   ReadData1;
    logic [DATA_WIDTH-1:0]   ReadData2;
    logic                    ReadBusy1;
    logic                    ReadBusy2;
    logic [ADDR_WIDTH-1:0]   WriteRegister;
    logic [DATA_WIDTH-1:0]   WriteData;
    logic [DATA_WIDTH/8-1:0] WriteByteEn;
    logic                    RegWrite;
    logic                    Reserve;
    logic [ADDR_WIDTH-1:0]   ReserveRegister;

    // Pipeline side: presents addresses, write data and strobes
    modport master (
        output ReadRegister1, ReadRegister2,
        output WriteRegister, WriteData, WriteByteEn, RegWrite,
        output Reserve, ReserveRegister,
        input  ReadData1, ReadData2, ReadBusy1, ReadBusy2
    );

    // Register file side
    modport slave (
        input  ReadRegister1, ReadRegister2,
        input  WriteRegister, WriteData, WriteByteEn, RegWrite,
        input  Reserve, ReserveRegister,
        output ReadData1, ReadData2, ReadBusy1, ReadBusy2
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised 2-read / 1-write register file with byte enables, optional
// hardwired zero register, optional write-to-read bypass, optional registered
// read data and a per-register pending (scoreboard) bit.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1,
    parameter bit SYNC_READ  = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    regfile_scoreboard_if.slave   bus
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    // Storage and scoreboard state
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pending;

    // Write / reserve qualification
    logic                  w_wr_to_zero;
    logic                  w_wr_en;
    logic                  w_wr_clear;
    logic                  w_rsv_en;
    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [DEPTH-1:0]      w_pending_next;

    // Per-port read plumbing
    logic [ADDR_WIDTH-1:0] w_raddr [2];
    logic [DATA_WIDTH-1:0] w_rdata [2];
    logic [1:0]            w_busy;

    // The zero register swallows writes and reserves when it is hardwired
    assign w_wr_to_zero = ZERO_REG && (bus.WriteRegister == '0);
    assign w_wr_en      = bus.RegWrite && !w_wr_to_zero;
    // Only a write that actually lands at least one byte retires a pending bit
    assign w_wr_clear   = w_wr_en && (|bus.WriteByteEn);
    assign w_rsv_en     = bus.Reserve && !(ZERO_REG && (bus.ReserveRegister == '0));

    // Expand per-byte enables into a bit mask over the data word
    always_comb begin
        w_wr_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w_wr_mask[8*i +: 8] = {8{bus.WriteByteEn[i]}};
        end
    end

    // Register array: byte-merged write into the addressed entry
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.WriteRegister] <= (r_regs[bus.WriteRegister] & ~w_wr_mask)
                                       | (bus.WriteData & w_wr_mask);
        end
    end

    // Next pending vector: clear on writeback first, then set on reserve so a
    // same-cycle reserve of the written register leaves it pending
    always_comb begin
        w_pending_next = r_pending;
        if (w_wr_clear) begin
            w_pending_next[bus.WriteRegister] = 1'b0;
        end
        if (w_rsv_en) begin
            w_pending_next[bus.ReserveRegister] = 1'b1;
        end
    end

    // Pending bit register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign w_raddr[0] = bus.ReadRegister1;
    assign w_raddr[1] = bus.ReadRegister2;

    // Both read ports are built from the same slice so they always agree
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  w_is_zero;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_stored;
        logic [DATA_WIDTH-1:0] w_merged;

        assign w_is_zero = ZERO_REG && (w_raddr[p] == '0);
        // w_wr_en already excludes the zero register, so no forwarding into it
        assign w_hit     = BYPASS && w_wr_en && (bus.WriteRegister == w_raddr[p]);
        assign w_stored  = r_regs[w_raddr[p]];

        // Merge in-flight write bytes over the stored value on a bypass hit
        always_comb begin
            w_merged = w_stored;
            if (w_hit) begin
                w_merged = (w_stored & ~w_wr_mask) | (bus.WriteData & w_wr_mask);
            end
            if (w_is_zero) begin
                w_merged = '0;
            end
        end

        // Busy is always combinational; a bypassed clearing write hides it early
        assign w_busy[p] = r_pending[w_raddr[p]] && !w_is_zero
                         && !(w_hit && w_wr_clear);

        if (SYNC_READ) begin : g_sync
            logic [DATA_WIDTH-1:0] r_rdata;

            // Registered read: capture the merged value at each edge
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= w_merged;
                end
            end

            assign w_rdata[p] = r_rdata;
        end else begin : g_comb
            assign w_rdata[p] = w_merged;
        end
    end

    assign bus.ReadData1 = w_rdata[0];
    assign bus.ReadData2 = w_rdata[1];
    assign bus.ReadBusy1 = w_busy[0];
    assign bus.ReadBusy2 = w_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Four instances share one stimulus:
//   a: defaults (zero reg, bypass, combinational read)
//   b: BYPASS=0
//   c: SYNC_READ=1
//   d: ZERO_REG=0
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rr1, rr2, wa, rsva;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic        rwr, rsv;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  regfile_scoreboard_if if_a ();
  regfile_scoreboard_if if_b ();
  regfile_scoreboard_if if_c ();
  regfile_scoreboard_if if_d ();

  assign if_a.ReadRegister1 = rr1;  assign if_a.ReadRegister2 = rr2;
  assign if_a.WriteRegister = wa;   assign if_a.WriteData = wd;
  assign if_a.WriteByteEn = wbe;    assign if_a.RegWrite = rwr;
  assign if_a.Reserve = rsv;        assign if_a.ReserveRegister = rsva;

  assign if_b.ReadRegister1 = rr1;  assign if_b.ReadRegister2 = rr2;
  assign if_b.WriteRegister = wa;   assign if_b.WriteData = wd;
  assign if_b.WriteByteEn = wbe;    assign if_b.RegWrite = rwr;
  assign if_b.Reserve = rsv;        assign if_b.ReserveRegister = rsva;

  assign if_c.ReadRegister1 = rr1;  assign if_c.ReadRegister2 = rr2;
  assign if_c.WriteRegister = wa;   assign if_c.WriteData = wd;
  assign if_c.WriteByteEn = wbe;    assign if_c.RegWrite = rwr;
  assign if_c.Reserve = rsv;        assign if_c.ReserveRegister = rsva;

  assign if_d.ReadRegister1 = rr1;  assign if_d.ReadRegister2 = rr2;
  assign if_d.WriteRegister = wa;   assign if_d.WriteData = wd;
  assign if_d.WriteByteEn = wbe;    assign if_d.RegWrite = rwr;
  assign if_d.Reserve = rsv;        assign if_d.ReserveRegister = rsva;

  regfile_scoreboard u_a (.Clk(clk), .Rst_n(rst_n), .bus(if_a));
  regfile_scoreboard #(.BYPASS(1'b0))    u_b (.Clk(clk), .Rst_n(rst_n), .bus(if_b));
  regfile_scoreboard #(.SYNC_READ(1'b1)) u_c (.Clk(clk), .Rst_n(rst_n), .bus(if_c));
  regfile_scoreboard #(.ZERO_REG(1'b0))  u_d (.Clk(clk), .Rst_n(rst_n), .bus(if_d));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rwr = 1'b0;
    rsv = 1'b0;
    wbe = 4'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rr1 = '0; rr2 = '0; wa = '0; rsva = '0; wd = '0;
    idle();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd1_a", if_a.ReadData1, 32'h0);
    chk("rst_rd1_c", if_c.ReadData1, 32'h0);
    chk("rst_busy1_a", 32'(if_a.ReadBusy1), 32'h0);
    #2 rst_n = 1'b1;

    // full write then read on both ports
    tick();
    rwr = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; wbe = 4'hF;
    tick();
    idle(); rr1 = 5'd5; rr2 = 5'd5;
    #1;
    chk("full_rd1_a", if_a.ReadData1, 32'hDEADBEEF);
    chk("full_rd2_a", if_a.ReadData2, 32'hDEADBEEF);
    chk("full_rd1_b", if_b.ReadData1, 32'hDEADBEEF);

    // byte write: byte 1 only
    rwr = 1'b1; wa = 5'd5; wd = 32'h000012FF; wbe = 4'b0010;
    #1;
    chk("byte_bypass_a", if_a.ReadData1, 32'hDEAD12EF);
    chk("byte_nobypass_b", if_b.ReadData1, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("byte_after_a", if_a.ReadData1, 32'hDEAD12EF);
    chk("byte_after_b", if_b.ReadData2, 32'hDEAD12EF);

    // zero register: write and reserve r0
    tick();
    rwr = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wbe = 4'hF; rsv = 1'b1; rsva = 5'd0; rr1 = 5'd0;
    #1;
    chk("zero_same_a", if_a.ReadData1, 32'h0);
    chk("zero_same_d", if_d.ReadData1, 32'hFFFFFFFF);
    tick();
    idle();
    #1;
    chk("zero_rd1_a", if_a.ReadData1, 32'h0);
    chk("zero_busy1_a", 32'(if_a.ReadBusy1), 32'h0);
    chk("plain_r0_rd1_d", if_d.ReadData1, 32'hFFFFFFFF);
    chk("plain_r0_busy1_d", 32'(if_d.ReadBusy1), 32'h1);

    // bypass on overwrite of r7
    tick();
    rwr = 1'b1; wa = 5'd7; wd = 32'h11111111; wbe = 4'hF;
    tick();
    wd = 32'h22222222; rr1 = 5'd7;
    #1;
    chk("bypass_a", if_a.ReadData1, 32'h22222222);
    chk("bypass_off_b", if_b.ReadData1, 32'h11111111);
    tick();
    idle();
    #1;
    chk("bypass_after_a", if_a.ReadData1, 32'h22222222);
    chk("bypass_after_b", if_b.ReadData1, 32'h22222222);

    // scoreboard on r9
    tick();
    rsv = 1'b1; rsva = 5'd9; rr2 = 5'd9;
    #1;
    chk("rsv_same_busy2_a", 32'(if_a.ReadBusy2), 32'h0);
    tick();
    idle();
    #1;
    chk("rsv_busy2_a", 32'(if_a.ReadBusy2), 32'h1);
    chk("rsv_busy2_c", 32'(if_c.ReadBusy2), 32'h1);
    tick();
    rwr = 1'b1; wa = 5'd9; wd = 32'h5; wbe = 4'h0;
    #1;
    chk("nobe_same_busy2_a", 32'(if_a.ReadBusy2), 32'h1);
    tick();
    idle();
    #1;
    chk("nobe_busy2_a", 32'(if_a.ReadBusy2), 32'h1);
    chk("nobe_rd2_a", if_a.ReadData2, 32'h0);
    tick();
    rwr = 1'b1; wa = 5'd9; wd = 32'h5; wbe = 4'hF;
    #1;
    chk("clr_same_busy2_a", 32'(if_a.ReadBusy2), 32'h0);
    chk("clr_same_busy2_b", 32'(if_b.ReadBusy2), 32'h1);
    chk("clr_same_rd2_a", if_a.ReadData2, 32'h5);
    tick();
    idle();
    #1;
    chk("clr_busy2_a", 32'(if_a.ReadBusy2), 32'h0);
    chk("clr_busy2_b", 32'(if_b.ReadBusy2), 32'h0);
    chk("clr_rd2_a", if_a.ReadData2, 32'h5);
    tick();
    rwr = 1'b1; wa = 5'd9; wd = 32'hCAFE0009; wbe = 4'hF; rsv = 1'b1; rsva = 5'd9;
    tick();
    idle(); rr1 = 5'd9;
    #1;
    chk("rsvwr_busy2_a", 32'(if_a.ReadBusy2), 32'h1);
    chk("rsvwr_busy1_a", 32'(if_a.ReadBusy1), 32'h1);
    chk("rsvwr_rd2_a", if_a.ReadData2, 32'hCAFE0009);
    chk("rsvwr_rd1_a", if_a.ReadData1, 32'hCAFE0009);

    // registered read latency
    tick();
    rwr = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; wbe = 4'hF; rr1 = 5'd0;
    tick();
    idle(); rr1 = 5'd3;
    #1;
    chk("sync_before_c", if_c.ReadData1, 32'h0);
    chk("sync_comb_a", if_a.ReadData1, 32'hA5A5A5A5);
    tick();
    chk("sync_after_c", if_c.ReadData1, 32'hA5A5A5A5);
    rwr = 1'b1; wa = 5'd3; wd = 32'h0000005A; wbe = 4'b0001;
    #1;
    chk("sync_hold_c", if_c.ReadData1, 32'hA5A5A5A5);
    tick();
    idle();
    #1;
    chk("sync_byte_c", if_c.ReadData1, 32'hA5A5A55A);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd1_c", if_c.ReadData1, 32'h0);
    chk("arst_rd1_a", if_a.ReadData1, 32'h0);
    chk("arst_busy2_a", 32'(if_a.ReadBusy2), 32'h0);

    // write and reserve held across an edge while in reset are dropped
    rwr = 1'b1; wa = 5'd3; wd = 32'hFFFFFFFF; wbe = 4'hF; rsv = 1'b1; rsva = 5'd3;
    tick();
    idle();
    #2 rst_n = 1'b1;
    #1;
    chk("rst_ovr_rd1_a", if_a.ReadData1, 32'h0);
    chk("rst_ovr_busy1_a", 32'(if_a.ReadBusy1), 32'h0);

    // every non-zero register reads back cleared
    for (int i = 1; i < 32; i++) begin
      rr1 = 5'(i);
      #1;
      chk($sformatf("rst_scan_r%0d", i), if_a.ReadData1, 32'h0);
    end

    // first write after release
    tick();
    rwr = 1'b1; wa = 5'd4; wd = 32'h12345678; wbe = 4'hF;
    tick();
    idle(); rr1 = 5'd4;
    #1;
    chk("post_rst_wr_a", if_a.ReadData1, 32'h12345678);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-ported register file for the lab processor datapath, replacing the fixed 32x32 register file. It provides two read ports and one byte-enabled write port, plus a hardwired zero register and selectable write-to-read bypass. Optional registered reads and a per-register pending scoreboard let a pipelined core detect reads of registers that still await writeback. It sits between decode (read/reserve) and writeback (write).

## Interface
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes/reserves; 0: register 0 is ordinary
- BYPASS, 1, 1: same-cycle write data forwarded to matching read ports
- SYNC_READ, 0, 0: combinational read; 1: read data registered on posedge Clk
- Clk  input  1  sole clock; all state updates on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- ReadRegister1  input  ADDR_WIDTH  read port 1 address
- ReadRegister2  input  ADDR_WIDTH  read port 2 address
- ReadData1  output  DATA_WIDTH  read port 1 data
- ReadData2  output  DATA_WIDTH  read port 2 data
- ReadBusy1  output  1  addressed register of port 1 is pending
- ReadBusy2  output  1  addressed register of port 2 is pending
- WriteRegister  input  ADDR_WIDTH  write address
- WriteData  input  DATA_WIDTH  write data
- WriteByteEn  input  DATA_WIDTH/8  per-byte write enable, bit i covers bits 8i+7:8i
- RegWrite  input  1  write strobe
- Reserve  input  1  mark ReserveRegister pending
- ReserveRegister  input  ADDR_WIDTH  register to reserve

## Operation
- Reset (Rst_n low, asynchronous): all registers = 0, all pending bits = 0; with SYNC_READ=1, ReadData1/2 = 0. ReadBusy1/2 = 0.
- Write: at posedge with RegWrite=1, each byte of reg[WriteRegister] with WriteByteEn bit set takes the corresponding WriteData byte; other bytes hold.
- Write with WriteByteEn all-zero: no data change, pending bit unchanged.
- Pending clear: write with RegWrite=1 and any WriteByteEn bit set clears pending[WriteRegister].
- Reserve: at posedge with Reserve=1, pending[ReserveRegister] set.
- Reserve and clearing write to the same register in one cycle: data written, pending ends set (reserve wins).
- ZERO_REG=1: writes and reserves to address 0 ignored; ReadData for address 0 = 0; ReadBusy for address 0 = 0.
- Read value: merged = stored register with, if BYPASS=1 and RegWrite=1 and WriteRegister equals read address (and not zero register), enabled bytes replaced by WriteData bytes.
- BYPASS=0: read returns stored value only (pre-write value in the write cycle).
- ReadBusyN = pending[ReadRegisterN] AND NOT (BYPASS=1 and a clearing write to the same address this cycle); always combinational from current addresses, independent of SYNC_READ.
- Both read ports may address the same register; identical results.

## Timing
- SYNC_READ=0: ReadData combinational, zero-cycle latency from address and, with BYPASS, from WriteData/WriteByteEn.
- SYNC_READ=1: ReadData at posedge N+1 reflects merged value presented at cycle N; one-cycle latency; holds until next edge.
- Write visible in stored state from the cycle after the posedge; with BYPASS, same cycle.
- Pending bit set/clear takes effect after the posedge; ReadBusy reflects it from the next cycle.
- Rst_n deassertion: first write/reserve accepted at the first posedge with Rst_n high.
- Reset asserted mid-operation overrides any same-cycle write or reserve.

## Test plan
- Reset: Rst_n=0 with prior contents -> all reads 0, ReadBusy1/2=0; deassert, read r1..r31 -> all 0.
- Full write/read: write r5=0xDEADBEEF, WriteByteEn=4'hF; next cycle ReadRegister1=5, ReadRegister2=5 -> both 0xDEADBEEF; byte write WriteByteEn=4'b0010 data 0x000012FF -> r5=0xDEAD12EF.
- Zero register: write r0=0xFFFFFFFF, reserve r0 -> ReadData1 for r0 = 0, ReadBusy1=0.
- Bypass: r7=0x11111111; same cycle RegWrite r7=0x22222222, ReadRegister1=7 -> ReadData1=0x22222222 with BYPASS=1, 0x11111111 with BYPASS=0.
- Scoreboard: Reserve r9 -> next cycle ReadBusy2=1 for r9; write r9=0x5 with WriteByteEn=0 -> still busy; write with 4'hF -> ReadBusy2=0 next cycle; reserve+write r9 same cycle -> busy stays 1, data=written value.
- SYNC_READ=1: r3=0xA5A5A5A5; set ReadRegister1=3 at cycle N -> ReadData1=0xA5A5A5A5 after posedge N+1, not before; async Rst_n mid-cycle -> ReadData1=0 immediately.
